// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared ALU select codes, ALUOp/funct codes and sequencer state for alu_ctrl_md.
package alu_ctrl_pkg;
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_SLL  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_SLT  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;
   localparam logic [3:0] ALU_ILL  = 4'b1111;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_R   = 2'b10;
   localparam logic [1:0] OP_I   = 2'b11;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MD   = 7'b0000001;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   function automatic logic [3:0] base_sel(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one-bit-per-cycle shift-add multiplier / restoring divider on magnitudes,
// with sign fix-up folded into the final step and divide special cases resolved at load.
module muldiv_iter
   import alu_ctrl_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            step,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            special,
   output logic            last,
   output logic [XLEN-1:0] result
);
   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

   logic [2*XLEN-1:0] acc, acc_n, full;
   logic [XLEN-1:0]   opb, a_abs, b_abs, q, r, res_n, spec_res;
   logic [XLEN:0]     sum, diff;
   logic [CW-1:0]     cnt;
   logic [2:0]        f3;
   logic              neg_q, neg_r, sa, sb;

   always_comb begin
      sa = rs1[XLEN-1] && (funct3[2] ? !funct3[0] : funct3 != F3_MULHU);
      sb = rs2[XLEN-1] && (funct3[2] ? !funct3[0] : !funct3[1]);
      a_abs = sa ? -rs1 : rs1;
      b_abs = sb ? -rs2 : rs2;
      special = funct3[2] && (rs2 == '0 || (!funct3[0] && rs1 == MIN && &rs2));
      spec_res = funct3[1] ? (rs2 == '0 ? rs1 : '0) : (rs2 == '0 ? '1 : MIN);
      // acc is {partial product, multiplier} for mul and {remainder, quotient} for div
      sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
      diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opb};
      acc_n = f3[2] ? {diff[XLEN] ? acc[2*XLEN-2:XLEN-1] : diff[XLEN-1:0], acc[XLEN-2:0], !diff[XLEN]}
                    : {sum, acc[XLEN-1:1]};
      full = neg_q ? -acc_n : acc_n;
      q = acc_n[XLEN-1:0];
      r = acc_n[2*XLEN-1:XLEN];
      res_n = f3[2] ? (f3[1] ? (neg_r ? -r : r) : (neg_q ? -q : q))
                    : (f3 == F3_MUL ? full[XLEN-1:0] : full[2*XLEN-1:XLEN]);
   end

   assign last = cnt == CW'(XLEN - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         opb <= '0;
         cnt <= '0;
         f3 <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         result <= '0;
      end else if (load) begin
         acc <= {{XLEN{1'b0}}, funct3[2] ? a_abs : b_abs};
         opb <= funct3[2] ? b_abs : a_abs;
         cnt <= '0;
         f3 <= funct3;
         neg_q <= sa ^ sb;
         neg_r <= sa;
         if (special) result <= spec_res;
      end else if (step) begin
         acc <= acc_n;
         cnt <= cnt + CW'(1);
         if (last) result <= res_n;
      end
   end
endmodule

// File: rtl/alu_ctrl_md.sv
// alu_ctrl_md: combinational ALU-select decode plus IDLE/CALC/DONE sequencer that runs
// RV32M ops on muldiv_iter behind valid/ready handshakes.
module alu_ctrl_md
   import alu_ctrl_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int M_EXT = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      alu_op,
   input  logic [31:0]     inst,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic            flush,
   output logic [3:0]      alu_sel,
   output logic            md_req,
   input  logic            in_valid,
   output logic            in_ready,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);
   state_t     state, state_n;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       r_ok, i_ok, accept, special, last, unused_bits;

   assign f3 = inst[14:12];
   assign f7 = inst[31:25];
   assign unused_bits = ^{inst[24:15], inst[11:0]};

   always_comb begin
      md_req = (M_EXT != 0) && alu_op == OP_R && f7 == F7_MD;
      r_ok = f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101));
      i_ok = f3 == 3'b001 ? f7 == F7_BASE : f3 == 3'b101 ? (f7 == F7_BASE || f7 == F7_ALT) : 1'b1;
      alu_sel = md_req ? ALU_ILL
              : alu_op == OP_ADD ? ALU_ADD
              : alu_op == OP_SUB ? ALU_SUB
              : alu_op == OP_R ? (r_ok ? base_sel(f3, inst[30]) : ALU_ILL)
              : f3 == 3'b000 ? ALU_ADD
              : i_ok ? base_sel(f3, inst[30]) : ALU_ILL;
   end

   assign accept = in_valid && state == S_IDLE && md_req;
   assign in_ready = state == S_IDLE;
   assign out_valid = state == S_DONE;

   always_comb begin
      state_n = state;
      if (state == S_IDLE && accept) state_n = special ? S_DONE : S_CALC;
      if (state == S_CALC && last) state_n = S_DONE;
      if (state == S_DONE && out_ready) state_n = S_IDLE;
      if (flush) state_n = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else state <= state_n;
   end

   muldiv_iter #(.XLEN(XLEN)) u_md (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (accept && !flush),
      .step    (state == S_CALC && !flush),
      .funct3  (f3),
      .rs1     (rs1),
      .rs2     (rs2),
      .special (special),
      .last    (last),
      .result  (result)
   );
endmodule

// File: tb/tb_alu_ctrl_md.sv
// tb_alu_ctrl_md: directed decode sweep and M-op/handshake/flush/reset vectors with hand-computed results.
module tb_alu_ctrl_md;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [1:0]  alu_op = 2'b00;
   logic [31:0] inst = '0, rs1 = '0, rs2 = '0;
   logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic [3:0]  alu_sel;
   logic        md_req, in_ready, out_valid;
   logic [31:0] result;
   int          nvec = 0, nerr = 0;

   always #5 clk = ~clk;

   alu_ctrl_md #(.XLEN(32), .M_EXT(1)) dut (
      .clk(clk), .rst_n(rst_n), .alu_op(alu_op), .inst(inst), .rs1(rs1), .rs2(rs2),
      .flush(flush), .alu_sel(alu_sel), .md_req(md_req), .in_valid(in_valid),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .result(result)
   );

   function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
      return {f7, 10'h000, f3, 12'h033};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      alu_op = 2'b10;
      inst = mk(7'b0000001, f3);
      rs1 = a;
      rs2 = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 1;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
   endtask

   task automatic mop(input string tag, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int elat);
      int lat;
      out_ready = 1'b1;
      issue(f3, a, b);
      wait_done(lat);
      chk({tag, " lat"}, lat, elat);
      chk(tag, result, exp);
      tick();
   endtask

   initial begin
      logic [31:0] row;
      logic [3:0]  exp4;
      int          lat;
      logic        seen;
      #12;
      chk("rst in_ready", {31'h0, in_ready}, 32'h1);
      chk("rst out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst result", result, 32'h0);
      rst_n = 1'b1;
      tick();
      for (int op = 0; op < 4; op++)
         for (int f = 0; f < 8; f++)
            for (int b = 0; b < 2; b++) begin
               alu_op = 2'(op);
               inst = mk(b != 0 ? 7'b0100000 : 7'b0000000, 3'(f));
               #1;
               row = op == 0 ? 32'h2222_2222 : op == 1 ? 32'h6666_6666
                   : op == 2 ? (b != 0 ? 32'hFF7F_FFF6 : 32'h0153_9842)
                   : (b != 0 ? 32'h0173_98F2 : 32'h0153_9842);
               exp4 = row[f*4 +: 4];
               chk($sformatf("dec op%0d f3=%0d b30=%0d", op, f, b), {28'h0, alu_sel}, {28'h0, exp4});
            end
      alu_op = 2'b10; inst = mk(7'b0000010, 3'b000); #1;
      chk("dec r f7=0000010", {28'h0, alu_sel}, 32'hF);
      chk("md_req r f7=0000010", {31'h0, md_req}, 32'h0);
      inst = mk(7'b0000001, 3'b000); #1;
      chk("md_req mul", {31'h0, md_req}, 32'h1);
      chk("dec mul sel", {28'h0, alu_sel}, 32'hF);
      alu_op = 2'b11; #1;
      chk("md_req i-type", {31'h0, md_req}, 32'h0);
      chk("dec i f7=0000001 f3=0", {28'h0, alu_sel}, 32'h2);
      tick();
      mop("MUL", 3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 33);
      mop("MULH", 3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 33);
      mop("MULHSU", 3'b010, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 33);
      mop("MULHU", 3'b011, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 33);
      mop("MULHU max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      mop("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33);
      mop("REM -7/2", 3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33);
      mop("DIVU 100/7", 3'b101, 32'd100, 32'd7, 32'd14, 33);
      mop("DIVU by 0", 3'b101, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 1);
      mop("REM by 0", 3'b110, 32'h1234_5678, 32'h0, 32'h1234_5678, 1);
      mop("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      mop("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
      out_ready = 1'b0;
      issue(3'b000, 32'd7, 32'd6);
      wait_done(lat);
      chk("bp lat", lat, 33);
      for (int i = 0; i < 10; i++) begin
         chk("bp result", result, 32'd42);
         chk("bp in_ready", {31'h0, in_ready}, 32'h0);
         chk("bp out_valid", {31'h0, out_valid}, 32'h1);
         tick();
      end
      out_ready = 1'b1;
      tick();
      chk("bp release out_valid", {31'h0, out_valid}, 32'h0);
      chk("bp release in_ready", {31'h0, in_ready}, 32'h1);
      issue(3'b101, 32'd100, 32'd7);
      repeat (4) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush out_valid", {31'h0, out_valid}, 32'h0);
      chk("flush in_ready", {31'h0, in_ready}, 32'h1);
      seen = 1'b0;
      repeat (40) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      chk("flush no out_valid", {31'h0, seen}, 32'h0);
      mop("REMU after flush", 3'b111, 32'd100, 32'd7, 32'd2, 33);
      flush = 1'b1;
      issue(3'b101, 32'd5, 32'd0);
      flush = 1'b0;
      chk("flush+accept out_valid", {31'h0, out_valid}, 32'h0);
      chk("flush+accept in_ready", {31'h0, in_ready}, 32'h1);
      tick();
      chk("flush+accept later", {31'h0, out_valid}, 32'h0);
      issue(3'b000, 32'd3, 32'd5);
      repeat (5) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("async rst out_valid", {31'h0, out_valid}, 32'h0);
      chk("async rst in_ready", {31'h0, in_ready}, 32'h1);
      chk("async rst result", result, 32'h0);
      #2 rst_n = 1'b1;
      tick();
      mop("MUL after reset", 3'b000, 32'd3, 32'd5, 32'd15, 33);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
